vga_vram_arbiter: RTL

VGA_VRAM_ARBITER -- requirements
Module: vga_vram_arbiter

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_vram_arbiter_if.sv | 29 ++
 rtl/vga_fb_addr.sv | 26 ++
 rtl/vga_vram_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA frame-buffer arbiter.
// Holds the default frame-buffer geometry, the screen resolution, the issue
// FSM state encoding and the read-tag record that follows a VRAM read until
// its data returns.
package vga_pkg;

    localparam int FB_W_DEF   = 320;
    localparam int FB_H_DEF   = 240;
    localparam int ADDR_W_DEF = 17;
    localparam int DATA_W_DEF = 12;
    localparam int H_RES      = 640;
    localparam int V_RES      = 480;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DISP = 2'd1,
        ST_CPU  = 2'd2
    } issue_state_t;

    // What to do with mem_rdata in the cycle it becomes valid.
    typedef struct packed {
        logic pix_load;  // update pix_rgb
        logic pix_zero;  // blanking tick: load 0 instead of VRAM data
        logic cpu_rd;    // return data to the CPU with cpu_rvalid
        logic cpu_zero;  // out-of-range CPU read: return 0
    } rd_tag_t;

endpackage

// File: rtl/vga_vram_arbiter_if.sv
// CPU access port of the VRAM arbiter.
// master: the CPU side (drives request, write flag, address, write data).
// slave : the arbiter side (drives cpu_ready, cpu_rvalid, cpu_rdata).
interface vga_vram_arbiter_if
    import vga_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rvalid, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rvalid, cpu_rdata
    );

endinterface

// File: rtl/vga_fb_addr.sv
// Combinational frame-buffer address generator.
// Maps a screen position to the word address of the 2x2 pixel block that
// contains it: (y/2)*320 + x/2, built from shifts and adds.
// Ports: x, y (scan column/row, 10 bits) -> addr (ADDR_W-bit word address).
module vga_fb_addr
    import vga_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] x_half;
    logic [ADDR_W-1:0] y_half;
    logic              unused_lsb;

    assign x_half     = ADDR_W'(x[9:1]);
    assign y_half     = ADDR_W'(y[9:1]);
    assign unused_lsb = x[0] ^ y[0];

    // 320 = 256 + 64, so the row offset is two shifted copies of y/2.
    assign addr = (y_half << 8) + (y_half << 6) + x_half;

endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter between display refresh and CPU accesses.
// One decision per clk; the winner is issued on registered mem_* outputs the
// next cycle. Display fetches have absolute priority on visible p_ticks.
// Read data is routed by a one-entry read tag: pix_rgb and cpu_rdata/rvalid
// update three clocks after the decision.
// Ports: clk, rst (sync, active-high); p_tick, pixel_x, pixel_y, video_on from
// the sync generator; cpu (CPU port interface, slave side); mem_en, mem_we,
// mem_addr, mem_wdata, mem_rdata to the VRAM; pix_rgb display pixel.
module vga_vram_arbiter
    import vga_pkg::*;
#(
    parameter int FB_W   = FB_W_DEF,
    parameter int FB_H   = FB_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 p_tick,
    input  logic [9:0]           pixel_x,
    input  logic [9:0]           pixel_y,
    input  logic                 video_on,
    vga_vram_arbiter_if.slave    cpu,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic [DATA_W-1:0]    pix_rgb
);

    localparam int              FB_WORDS = FB_W * FB_H;
    localparam logic [ADDR_W:0] FB_LIMIT = FB_WORDS[ADDR_W:0];

    logic [ADDR_W-1:0] fb_addr;
    logic              disp_req;
    logic              blank_tick;
    logic              cpu_oob;
    logic              cpu_ready;

    issue_state_t      state_p1;
    issue_state_t      state_d;
    logic              mem_en_d;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;

    logic              cpu_we_p1;
    logic              oob_p1;
    logic              blank_p1;
    rd_tag_t           tag_d;
    rd_tag_t           tag_p2;

    logic              cpu_rvalid_p3;
    logic [DATA_W-1:0] cpu_rdata_p3;

    vga_fb_addr #(
        .ADDR_W (ADDR_W)
    ) u_fb_addr (
        .x    (pixel_x),
        .y    (pixel_y),
        .addr (fb_addr)
    );

    assign disp_req   = p_tick & video_on;
    assign blank_tick = p_tick & ~video_on;
    assign cpu_oob    = ({1'b0, cpu.cpu_addr} >= FB_LIMIT);
    assign cpu_ready  = cpu.cpu_req & ~disp_req & ~rst;

    assign cpu.cpu_ready  = cpu_ready;
    assign cpu.cpu_rvalid = cpu_rvalid_p3;
    assign cpu.cpu_rdata  = cpu_rdata_p3;

    // Decision (cycle n): pick the winner and form the next mem_* values.
    always_comb begin
        state_d     = ST_IDLE;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (disp_req) begin
            state_d    = ST_DISP;
            mem_en_d   = 1'b1;
            mem_addr_d = fb_addr;
        end else if (cpu_ready) begin
            state_d = ST_CPU;
            // Out-of-range accesses are accepted but never reach the VRAM.
            if (!cpu_oob) begin
                mem_en_d    = 1'b1;
                mem_we_d    = cpu.cpu_we;
                mem_addr_d  = cpu.cpu_addr;
                mem_wdata_d = cpu.cpu_we ? cpu.cpu_wdata : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1 <= ST_IDLE;
        end else begin
            state_p1 <= state_d;
        end
    end

    // Issue (cycle n+1): build the read tag for the data arriving in n+2.
    always_comb begin
        tag_d          = '0;
        tag_d.pix_load = (state_p1 == ST_DISP) | blank_p1;
        tag_d.pix_zero = blank_p1;
        tag_d.cpu_rd   = (state_p1 == ST_CPU) & ~cpu_we_p1;
        tag_d.cpu_zero = oob_p1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            cpu_we_p1     <= 1'b0;
            oob_p1        <= 1'b0;
            blank_p1      <= 1'b0;
            tag_p2        <= '0;
            pix_rgb       <= '0;
            cpu_rvalid_p3 <= 1'b0;
            cpu_rdata_p3  <= '0;
        end else begin
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            cpu_we_p1 <= cpu.cpu_we;
            oob_p1    <= cpu_oob;
            blank_p1  <= blank_tick;
            tag_p2    <= tag_d;
            // Return (cycle n+2 -> visible n+3): route VRAM data by tag.
            if (tag_p2.pix_load) begin
                pix_rgb <= tag_p2.pix_zero ? '0 : mem_rdata;
            end
            cpu_rvalid_p3 <= tag_p2.cpu_rd;
            if (tag_p2.cpu_rd) begin
                cpu_rdata_p3 <= tag_p2.cpu_zero ? '0 : mem_rdata;
            end
        end
    end

endmodule
